// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle add/nor/rotate/not/sub and an optional shift-add multiplier.
// Define MULTICYCLE_ALU_MUL_EN to build the multiplier; otherwise op 110 is treated as reserved.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef MULTICYCLE_ALU_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
`endif
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] ror;
    logic [WIDTH-1:0] quick_result;

`ifdef MULTICYCLE_ALU_MUL_EN
    localparam int CNT_W = SHW + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             zero_hold;

    always_comb begin
        acc_next = mplier[0] ? acc + mcand : acc;
    end
`endif

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign amt  = a[SHW-1:0];

    // Index arithmetic wraps modulo WIDTH because it is truncated to SHW bits.
    always_comb begin
        rol = '0;
        ror = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rol[i] = b[SHW'(i - amt)];
            ror[i] = b[SHW'(i + amt)];
        end
    end

    always_comb begin
        quick_result = '0;
        case (op)
            3'b000:  quick_result = a + b;
            3'b001:  quick_result = ~(a | b);
            3'b010:  quick_result = rol;
            3'b011:  quick_result = ror;
            3'b100:  quick_result = ~a;
            3'b101:  quick_result = a - b;
            default: quick_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            result <= '0;
            zero   <= 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            zero_hold <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef MULTICYCLE_ALU_MUL_EN
                        if (op == 3'b110) begin
                            mcand     <= a;
                            mplier    <= b;
                            acc       <= '0;
                            cnt       <= CNT_W'(WIDTH);
                            zero_hold <= (a == b);
                            state     <= S_MUL;
                        end else begin
                            result <= quick_result;
                            zero   <= (a == b);
                            state  <= S_DONE;
                        end
`else
                        result <= quick_result;
                        zero   <= (a == b);
                        state  <= S_DONE;
`endif
                    end
                end
`ifdef MULTICYCLE_ALU_MUL_EN
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Final step: publish the sum this edge so done follows WIDTH+1 cycles after start.
                    if (cnt == CNT_W'(1)) begin
                        result <= acc_next;
                        zero   <= zero_hold;
                        state  <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed vectors, corner sequences, random ops vs. a reference model.
module tb_multicycle_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned n;
        longint unsigned p;
        n = x % W;
        p = 0;
        case (o)
            3'd0: return x + y;
            3'd1: return ~(x | y);
            3'd2: return (y << n) | (y >> (W - n));
            3'd3: return (y >> n) | (y << (W - n));
            3'd4: return ~x;
            3'd5: return x - y;
`ifdef MULTICYCLE_ALU_MUL_EN
            3'd6: begin
                p = longint'(x) * longint'(y);
                return p[W-1:0];
            end
`endif
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o);
`ifdef MULTICYCLE_ALU_MUL_EN
        if (o == 3'd6) return W + 1;
`endif
        return 1;
    endfunction

    // Called at a negedge in an IDLE cycle; returns at the negedge of the cycle after done.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] res, output logic z, output int cyc,
                          output logic busy_after, output logic done_after);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        cyc   = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 200);
        res = result;
        z   = zero;
        @(negedge clk);
        busy_after = busy;
        done_after = done;
    endtask

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   ro;
        logic         z;
        logic         ba;
        logic         da;
        int           cyc;
        int           holds;
        int           dones;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vecs[1]  = '{3'd1, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0};
        vecs[2]  = '{3'd2, 32'h0000_0024, 32'h8000_0001, 32'h0000_0018, 1'b0};
        vecs[3]  = '{3'd3, 32'h0000_0024, 32'h8000_0001, 32'h1800_0000, 1'b0};
        vecs[4]  = '{3'd2, 32'hFFFF_FFE0, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[5]  = '{3'd3, 32'h0000_001F, 32'h0000_0001, 32'h0000_0002, 1'b0};
        vecs[6]  = '{3'd4, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{3'd5, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1};
        vecs[8]  = '{3'd5, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{3'd7, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
`ifdef MULTICYCLE_ALU_MUL_EN
        vecs[10] = '{3'd6, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 1'b0};
        vecs[11] = '{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
`else
        vecs[10] = '{3'd6, 32'h0001_0003, 32'h0001_0005, 32'h0000_0000, 1'b0};
        vecs[11] = '{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
`endif
        vecs[12] = '{3'd2, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 32'h0);
        check("reset zero", zero, 1'b0);

        // First start in the very first cycle reset is low.
        reset = 1'b0;
        run_op(3'd0, 32'hFFFF_FFFF, 32'h2, res, z, cyc, ba, da);
        check("first add result", res, 32'h1);
        check("first add zero", z, 1'b0);
        check("first add latency", cyc, 1);
        check("first add done pulse width", da, 1'b0);
        check("first add busy after", ba, 1'b0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, cyc, ba, da);
            check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d zero", i), z, vecs[i].exp_zero);
            check($sformatf("vec%0d latency", i), cyc, ref_latency(vecs[i].op));
        end

        // Back-to-back sub then not.
        run_op(3'd5, 32'h1234, 32'h1234, res, z, cyc, ba, da);
        check("b2b sub result", res, 32'h0);
        check("b2b sub zero", z, 1'b1);
        run_op(3'd4, 32'h0, 32'h5, res, z, cyc, ba, da);
        check("b2b not result", res, 32'hFFFF_FFFF);
        check("b2b not zero", z, 1'b0);

        // Mul with start pulses while busy; result must hold until done.
        prev  = result;
        holds = 0;
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h0001_0003;
        b     = 32'h0001_0005;
        cyc   = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done || cyc >= 200) begin
                start = 1'b0;
                break;
            end
            if (result !== prev) holds++;
            start = (cyc % 4 == 1);
            op    = 3'd0;
            a     = 32'hFFFF_FFFF;
            b     = 32'h1;
        end
        check("mul latency", cyc, ref_latency(3'd6));
        check("mul result", result, ref_result(3'd6, 32'h0001_0003, 32'h0001_0005));
        check("mul zero", zero, 1'b0);
        check("mul busy at done", busy, 1'b1);
        check("mul result held while busy", holds, 0);
        @(negedge clk);
        check("mul idle after done", busy, 1'b0);
        check("mul done single pulse", done, 1'b0);

        // Reset on cycle 10 of a mul.
        dones = 0;
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h0000_0007;
        b     = 32'h0000_0009;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", result, 32'h0);
        check("abort zero", zero, 1'b0);
`ifdef MULTICYCLE_ALU_MUL_EN
        check("abort no done pulse", dones, 0);
`else
        check("reserved mul done pulses", dones, 1);
`endif
        reset = 1'b0;
        run_op(3'd0, 32'h5, 32'h7, res, z, cyc, ba, da);
        check("post-abort add result", res, 32'hC);
        check("post-abort add latency", cyc, 1);

        for (int n = 0; n < 300; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            if (ro == 3'd2 || ro == 3'd3) begin
                if ($urandom_range(0, 3) == 0) ra[4:0] = 5'd0;
            end
            run_op(ro, ra, rb, res, z, cyc, ba, da);
            check($sformatf("rand%0d op%0d result", n, ro), res, ref_result(ro, ra, rb));
            check($sformatf("rand%0d zero", n), z, (ra == rb));
            check($sformatf("rand%0d latency", n), cyc, ref_latency(ro));
            check($sformatf("rand%0d idle after", n), {ba, da}, 2'b00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
